// File: rtl/step_sequencer_if.sv
// Control, pattern-programming and playback-status bundle for step_sequencer.
// The master side is the user control logic; the slave side is the sequencer.
interface step_sequencer_if #(
  parameter int STEP_W = 3,
  parameter int CNT_W  = 24
);
  logic              start;
  logic              stop;
  logic              loop_en;
  logic [CNT_W-1:0]  step_period;
  logic [CNT_W-1:0]  gate_period;
  logic              wr_en;
  logic [STEP_W-1:0] wr_addr;
  logic [3:0]        wr_note;
  logic [3:0]        note;
  logic [STEP_W-1:0] step_idx;
  logic              playing;
  logic              step_tick;
  logic              done;

  modport master (
    output start, stop, loop_en, step_period, gate_period, wr_en, wr_addr, wr_note,
    input  note, step_idx, playing, step_tick, done
  );

  modport slave (
    input  start, stop, loop_en, step_period, gate_period, wr_en, wr_addr, wr_note,
    output note, step_idx, playing, step_tick, done
  );
endinterface

// File: rtl/step_sequencer.sv
// Pattern step sequencer: plays an NUM_STEPS-entry RAM of 4-bit note codes,
// one step per step_period clocks, each note gated to the first gate_period clocks.
module step_sequencer #(
  parameter int NUM_STEPS = 8,
  parameter int STEP_W    = 3,
  parameter int CNT_W     = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  step_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, NOTE_ON, NOTE_OFF} state_t;

  state_t            r_state;
  logic [3:0]        r_pat [NUM_STEPS];
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_step_per;
  logic [CNT_W-1:0]  r_gate_per;
  logic [STEP_W-1:0] r_idx;
  logic [3:0]        r_note;
  logic              r_playing;
  logic              r_tick;
  logic              r_done;

  logic              w_start_ok;
  logic              w_step_end;
  logic              w_last;
  logic              w_gate_end;
  logic [STEP_W-1:0] w_next_idx;
  logic [STEP_W-1:0] w_load_idx;
  logic [3:0]        w_load_note;
  logic              w_load_silent;

  always_comb begin
    w_start_ok    = bus.start && !bus.stop && (bus.step_period != '0);
    w_step_end    = (r_cnt == r_step_per - CNT_W'(1));
    w_last        = (r_idx == STEP_W'(NUM_STEPS - 1));
    w_gate_end    = (r_cnt == r_gate_per - CNT_W'(1)) && (r_gate_per < r_step_per);
    // Power-of-2 pattern length: the increment wraps 7->0 on its own.
    w_next_idx    = r_idx + STEP_W'(1);
    w_load_idx    = (r_state == IDLE) ? '0 : w_next_idx;
    // Same-cycle write to the entry being loaded is forwarded.
    w_load_note   = (bus.wr_en && (bus.wr_addr == w_load_idx)) ? bus.wr_note
                                                               : r_pat[w_load_idx];
    w_load_silent = (r_state == IDLE) ? (bus.gate_period == '0) : (r_gate_per == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_STEPS; i++) r_pat[i] <= '0;
    end else if (bus.wr_en) begin
      r_pat[bus.wr_addr] <= bus.wr_note;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_step_per <= '0;
      r_gate_per <= '0;
      r_idx      <= '0;
      r_note     <= '0;
      r_playing  <= 1'b0;
      r_tick     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_note <= '0;
          if (w_start_ok) begin
            r_step_per <= bus.step_period;
            r_gate_per <= bus.gate_period;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_tick     <= 1'b1;
            r_playing  <= 1'b1;
            r_state    <= w_load_silent ? NOTE_OFF : NOTE_ON;
            r_note     <= w_load_silent ? 4'd0 : w_load_note;
          end
        end
        NOTE_ON, NOTE_OFF: begin
          if (bus.stop) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_note    <= '0;
            r_playing <= 1'b0;
          end else if (w_step_end) begin
            r_cnt <= '0;
            if (w_last && !bus.loop_en) begin
              r_state   <= IDLE;
              r_idx     <= '0;
              r_note    <= '0;
              r_playing <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              r_idx   <= w_next_idx;
              r_tick  <= 1'b1;
              r_state <= w_load_silent ? NOTE_OFF : NOTE_ON;
              r_note  <= w_load_silent ? 4'd0 : w_load_note;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if ((r_state == NOTE_ON) && w_gate_end) begin
              r_state <= NOTE_OFF;
              r_note  <= '0;
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          r_note    <= '0;
          r_playing <= 1'b0;
        end
      endcase
    end
  end

  assign bus.note      = r_note;
  assign bus.step_idx  = r_idx;
  assign bus.playing   = r_playing;
  assign bus.step_tick = r_tick;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_step_sequencer.sv
// Scoreboard bench for step_sequencer: a time-since-start reference model predicts
// every post-edge output; a negedge monitor pops and compares.
module tb_step_sequencer;
  localparam int N  = 8;
  localparam int SW = 3;
  localparam int CW = 24;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  step_sequencer_if #(.STEP_W(SW), .CNT_W(CW)) bus();
  step_sequencer #(.NUM_STEPS(N), .STEP_W(SW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0]    note;
    logic [SW-1:0] idx;
    logic          playing;
    logic          tick;
    logic          done;
  } obs_t;

  obs_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: playback position is cycles elapsed since the accepted start.
  int          m_pat [N];
  bit          m_play = 1'b0;
  int unsigned m_t, m_sp, m_gp;
  int          m_cur;

  task automatic check(input string name, input obs_t exp);
    obs_t a;
    a = {bus.note, bus.step_idx, bus.playing, bus.step_tick, bus.done};
    n_vec++;
    if (a !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got note=%0d idx=%0d play=%0b tick=%0b done=%0b, want note=%0d idx=%0d play=%0b tick=%0b done=%0b",
               name, $time, a.note, a.idx, a.playing, a.tick, a.done,
               exp.note, exp.idx, exp.playing, exp.tick, exp.done);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) check("scoreboard", q.pop_front());
  end

  task automatic tick();
    int   np [N];
    bit   d;
    obs_t e;
    d  = 1'b0;
    np = m_pat;
    if (bus.wr_en) np[bus.wr_addr] = int'(bus.wr_note);
    if (m_play) begin
      if (bus.stop) m_play = 1'b0;
      else if ((m_t % m_sp == m_sp - 1) && ((m_t / m_sp) % N == N - 1) && !bus.loop_en) begin
        m_play = 1'b0;
        d      = 1'b1;
      end else begin
        m_t++;
        if (m_t % m_sp == 0) m_cur = np[(m_t / m_sp) % N];
      end
    end else if (bus.start && !bus.stop && bus.step_period != 0) begin
      m_play = 1'b1;
      m_sp   = int'(bus.step_period);
      m_gp   = int'(bus.gate_period);
      m_t    = 0;
      m_cur  = np[0];
    end
    m_pat  = np;
    e      = '0;
    e.done = d;
    if (m_play) begin
      e.playing = 1'b1;
      e.idx     = SW'((m_t / m_sp) % N);
      e.tick    = (m_t % m_sp == 0);
      e.note    = (m_t % m_sp < m_gp) ? 4'(m_cur) : 4'd0;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.wr_en = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic go(input int sp, input int gp, input bit lp);
    bus.step_period = CW'(sp);
    bus.gate_period = CW'(gp);
    bus.loop_en     = lp;
    bus.start       = 1'b1;
    tick();
  endtask

  task automatic wr(input int a, input int nt);
    bus.wr_en   = 1'b1;
    bus.wr_addr = SW'(a);
    bus.wr_note = 4'(nt);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.loop_en     = 1'b0;
    bus.step_period = '0;
    bus.gate_period = '0;
    bus.wr_en       = 1'b0;
    bus.wr_addr     = '0;
    bus.wr_note     = '0;
    foreach (m_pat[i]) m_pat[i] = 0;
    #12;
    check("reset_state", '0);
    #10 rst_n = 1'b1;
    run(3);

    for (int i = 0; i < N; i++) begin
      wr(i, i + 1);
      tick();
    end

    // T1: single pass, gated notes, done at 80 clocks
    go(10, 6, 1'b0);
    run(85);

    // T2: legato loop over several passes, then stop
    go(4, 4, 1'b1);
    run(100);
    bus.stop = 1'b1;
    tick();
    run(2);

    // T3: REST entry
    wr(2, 0);
    tick();
    go(5, 3, 1'b0);
    run(45);

    // T4: stop at cnt=3 of step 5 together with a start
    go(6, 4, 1'b0);
    run(33);
    bus.stop  = 1'b1;
    bus.start = 1'b1;
    tick();
    run(3);

    // T5: zero step period ignored; write bypass on step-3 load
    go(0, 3, 1'b0);
    run(3);
    go(5, 5, 1'b0);
    run(14);
    wr(3, 6);
    tick();
    run(30);

    // gate 0, gate > step, step_period 1
    go(3, 0, 1'b0);
    run(26);
    go(2, 9, 1'b0);
    run(18);
    go(1, 1, 1'b0);
    run(10);

    // randomized phase
    for (int i = 0; i < 1500; i++) begin
      bus.wr_en       = ($urandom_range(0, 3) == 0);
      bus.wr_addr     = SW'($urandom_range(0, N - 1));
      bus.wr_note     = 4'($urandom_range(0, 15));
      bus.start       = ($urandom_range(0, 9) == 0);
      bus.stop        = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 19) == 0) bus.loop_en = $urandom_range(0, 1) == 1;
      bus.step_period = CW'($urandom_range(0, 6));
      bus.gate_period = CW'($urandom_range(0, 7));
      tick();
    end

    // T6: asynchronous reset mid-step 4, then replay of a cleared pattern
    bus.stop = 1'b1;
    tick();
    go(5, 5, 1'b0);
    run(22);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", '0);
    m_play = 1'b0;
    foreach (m_pat[i]) m_pat[i] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    go(3, 3, 1'b0);
    run(26);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending entries, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
